regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

- Shares the single register-file write port between two writeback producers: requester 0 is the ALU, requester 1 is the load/store unit.
- Round-robin arbitration with a valid/ready handshake per requester.
- Drives the register file's write port from a registered stage.
- Holds a 32-entry pending scoreboard so the decode stage can stall reads of registers whose writeback has not landed.

## Interface
Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register index width (32 registers; x0 hardwired zero)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- flush  in  1  clears scoreboard; blocks grants that cycle
- rsv_valid  in  1  decode reserves a destination register
- rsv_reg  in  ADDR_W  register being reserved
- chk_reg1  in  ADDR_W  source register 1 queried by decode
- chk_reg2  in  ADDR_W  source register 2 queried by decode
- hazard1  out  1  chk_reg1 pending (combinational)
- hazard2  out  1  chk_reg2 pending (combinational)
- req0_valid  in  1  ALU writeback request
- req0_ready  out  1  ALU request granted this cycle
- req0_reg  in  ADDR_W  ALU destination register
- req0_data  in  DATA_W  ALU result
- req1_valid, req1_ready, req1_reg, req1_data: same as req0_*, for the load/store unit
- rf_write_enable  out  1  register-file write enable
- rf_write_reg  out  ADDR_W  register-file write index
- rf_write_data  out  DATA_W  register-file write data

## Operation
**Arbitration**
- Each cycle, at most one requester is granted; readyN is combinational from the valid inputs, last_grant and flush.
- If exactly one requester is valid, it is granted.
- If both are valid, the requester not equal to last_grant is granted.
- last_grant updates to the granted index on every grant.
- A requester must hold valid, reg and data stable until ready is seen. Transfer occurs when valid && ready.
- While flush is high, both readies are 0 and no transfer occurs.

**Write stage**
- On a transfer, the granted reg and data are registered. The write stage presents them on rf_write_* in the following cycle.
- rf_write_enable is 1 only if the transferred reg != 0. A request to x0 is accepted and discarded.
- There is no back-pressure from the register file.

**Scoreboard (pending[31:1])**
- rsv_valid with rsv_reg != 0 sets pending[rsv_reg] at the next edge.
- When rf_write_enable = 1, pending[rf_write_reg] clears at the next edge. This is the same edge at which the register file stores the data.
- If a set and a clear target the same register in the same cycle, the set wins (a newer producer has been issued).
- flush clears all pending bits. A concurrent rsv_valid is ignored.
- hazardN = (chk_regN != 0) && pending[chk_regN]. Reads of x0 never report a hazard.

**Reset**
- pending = 0
- last_grant = 1, so req0 wins the first contention
- write stage empty
- rf_write_enable = 0, rf_write_reg = 0, rf_write_data = 0
- readies follow the combinational rules from the first cycle after reset deasserts
- Reset mid-operation drops any registered write. That write never reaches the register file.

## Timing
- Transfer at cycle N → rf_write_enable high in cycle N+1 → register file updated and pending bit cleared at the end of N+1.
- Decode reading in cycle N+2 sees the new value and hazard = 0.
- Sustained throughput is one writeback per cycle total.
- With both requesters continuously valid, grants alternate: 0, 1, 0, 1…
- Worst-case wait for a requester is 1 cycle.
- The write stage never stalls, so a grant is never lost.
- hazard outputs are combinational from current pending state; they do not reflect a same-cycle rsv or write.

## Structure
- Package regfile_pkg:
  - DATA_W and ADDR_W constants
  - REG_ZERO = 0
  - NUM_REGS = 32
  - typedef wb_req_t {reg, data} shared by all writeback producers
- Sub-module rr_arbiter2: 2-input round-robin arbiter.
  - Inputs: valid[1:0], flush.
  - Outputs: one-hot grant, plus the last_grant state register.
- Scoreboard and write stage stay in the top module.

## Test plan
- Reset, then idle: all outputs 0. req0_valid alone (reg 5, data 0xDEADBEEF) → req0_ready=1 same cycle. Next cycle: rf_write_enable=1, rf_write_reg=5, rf_write_data=0xDEADBEEF.
- Both valid continuously for 4 cycles after reset (req0 reg 3, req1 reg 4) → grant order 0, 1, 0, 1. Each requester holds until granted.
- rsv_valid reg 7 → hazard1=1 for chk_reg1=7. req1 writes reg 7 → hazard1 stays 1 through the rf_write_enable cycle and is 0 the cycle after.
- Same cycle: rsv_valid reg 9 and rf_write_enable on reg 9 → pending[9] remains 1.
- Request to reg 0 with data 0x1234 → accepted (ready=1), rf_write_enable stays 0. rsv_reg=0 and chk_reg1=0 → hazard1=0.
- flush while req0_valid=1 and pending = {2, 6} → req0_ready=0 that cycle, pending all clear next cycle. reset asserted the cycle after a transfer → rf_write_enable=0, no write issued.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback path.
//   DATA_W / ADDR_W : register data width and register index width
//   REG_ZERO        : index of the hardwired-zero register
//   NUM_REGS        : number of architectural registers
//   wb_req_t        : one writeback request (destination index + data)
package regfile_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  // "reg" is a keyword, so the destination field is named dst.
  typedef struct packed {
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback handshake bundle between the two producers and the arbiter.
//   req0_* : ALU writeback (valid/request in, ready out of the arbiter)
//   req1_* : load/store unit writeback
// Modports: master = producer side, slave = arbiter side.
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic    req0_valid;
  logic    req0_ready;
  wb_req_t req0;
  logic    req1_valid;
  logic    req1_ready;
  wb_req_t req1;

  modport master (output req0_valid, req0, req1_valid, req1,
                  input  req0_ready, req1_ready);
  modport slave  (input  req0_valid, req0, req1_valid, req1,
                  output req0_ready, req1_ready);
endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter.
//   clk, reset : clock, synchronous active-high reset
//   valid[1:0] : request lines
//   flush      : suppresses all grants this cycle
//   grant[1:0] : one-hot grant (combinational)
//   last_grant : index of the most recent grant (state)
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       flush,
  output logic [1:0] grant,
  output logic       last_grant
);

  always_comb begin
    grant = 2'b00;
    if (!flush) begin
      unique case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        // On contention, favour whoever did not win last time.
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // Reset to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (reset)        last_grant <= 1'b1;
    else if (|grant)  last_grant <= grant[1];
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the ALU (req0) and the
// load/store unit (req1), and tracks pending destination registers.
//   clk, reset        : clock, synchronous active-high reset
//   flush             : clears scoreboard, blocks grants this cycle
//   rsv_valid/rsv_reg : decode reserves a destination register
//   chk_reg1/2        : decode source queries -> hazard1/2 (combinational)
//   wb                : producer handshake bundle (slave side)
//   rf_write_*        : registered register-file write port
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_reg,
  input  logic [ADDR_W-1:0] chk_reg1,
  input  logic [ADDR_W-1:0] chk_reg2,
  output logic              hazard1,
  output logic              hazard2,
  regfile_wb_arbiter_if.slave wb,
  output logic              rf_write_enable,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data
);

  logic [1:0]          valid;
  logic [1:0]          grant;
  logic                last_grant;
  logic                xfer;
  wb_req_t             sel;
  logic                wb_vld_q;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;

  assign valid = {wb.req1_valid, wb.req0_valid};

  // Reset also blocks grants so nothing is accepted into a stage being cleared.
  rr_arbiter2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .valid      (valid),
    .flush      (flush | reset),
    .grant      (grant),
    .last_grant (last_grant)
  );

  assign wb.req0_ready = grant[0];
  assign wb.req1_ready = grant[1];
  assign xfer          = |grant;
  assign sel           = grant[1] ? wb.req1 : wb.req0;

  // Write stage: x0 requests are accepted but never raise the enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_vld_q      <= 1'b0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
    end else begin
      wb_vld_q <= xfer && (sel.dst != REG_ZERO);
      if (xfer) begin
        rf_write_reg  <= sel.dst;
        rf_write_data <= sel.data;
      end
    end
  end

  // Gate with reset so a write sitting in the stage when reset hits is dropped.
  assign rf_write_enable = wb_vld_q & ~reset;

  // Scoreboard: clear on landing write, then set on reserve so a newer
  // producer of the same register wins.
  always_comb begin
    pending_nxt = pending;
    if (rf_write_enable)
      pending_nxt[rf_write_reg] = 1'b0;
    if (rsv_valid && (rsv_reg != '0))
      pending_nxt[rsv_reg] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) pending <= '0;
    else                pending <= pending_nxt;
  end

  assign hazard1 = (chk_reg1 != '0) && pending[chk_reg1];
  assign hazard2 = (chk_reg2 != '0) && pending[chk_reg2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: inputs driven 1 time unit after
// the rising edge, outputs sampled on the falling edge.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic              clk = 1'b0;
  logic              reset, flush, rsv_valid;
  logic [ADDR_W-1:0] rsv_reg, chk_reg1, chk_reg2;
  logic              hazard1, hazard2;
  logic              rf_write_enable;
  logic [ADDR_W-1:0] rf_write_reg;
  logic [DATA_W-1:0] rf_write_data;
  int                n_chk = 0;
  int                n_err = 0;

  regfile_wb_arbiter_if wb();

  regfile_wb_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .rsv_valid       (rsv_valid),
    .rsv_reg         (rsv_reg),
    .chk_reg1        (chk_reg1),
    .chk_reg2        (chk_reg2),
    .hazard1         (hazard1),
    .hazard2         (hazard2),
    .wb              (wb.slave),
    .rf_write_enable (rf_write_enable),
    .rf_write_reg    (rf_write_reg),
    .rf_write_data   (rf_write_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; rsv_valid = 1'b0;
    rsv_reg = '0; chk_reg1 = '0; chk_reg2 = '0;
    wb.req0_valid = 1'b0; wb.req0 = '0;
    wb.req1_valid = 1'b0; wb.req1 = '0;
    step; step;
    reset = 1'b0;

    // Idle after reset
    smp;
    check("idle_we",   rf_write_enable, 0);
    check("idle_reg",  rf_write_reg, 0);
    check("idle_data", rf_write_data, 0);
    check("idle_rdy0", wb.req0_ready, 0);
    check("idle_rdy1", wb.req1_ready, 0);
    check("idle_hz1",  hazard1, 0);

    // Single ALU request
    step;
    wb.req0_valid = 1'b1; wb.req0 = '{dst: 5'd5, data: 32'hDEADBEEF};
    smp;
    check("single_rdy0", wb.req0_ready, 1);
    check("single_rdy1", wb.req1_ready, 0);
    step;
    wb.req0_valid = 1'b0;
    smp;
    check("single_we",   rf_write_enable, 1);
    check("single_reg",  rf_write_reg, 5);
    check("single_data", rf_write_data, 32'hDEADBEEF);

    // Contention after reset: 0,1,0,1
    step;
    reset = 1'b1;
    step;
    reset = 1'b0;
    wb.req0_valid = 1'b1; wb.req0 = '{dst: 5'd3, data: 32'hA};
    wb.req1_valid = 1'b1; wb.req1 = '{dst: 5'd4, data: 32'hB};
    for (int i = 0; i < 4; i++) begin
      smp;
      check("rr_rdy0", wb.req0_ready, (i % 2 == 0));
      check("rr_rdy1", wb.req1_ready, (i % 2 == 1));
      if (i == 0) check("rr_we0", rf_write_enable, 0);
      else        check("rr_reg", rf_write_reg, (i % 2 == 1) ? 3 : 4);
      step;
    end
    wb.req0_valid = 1'b0; wb.req1_valid = 1'b0;
    smp;
    check("rr_last_we",  rf_write_enable, 1);
    check("rr_last_reg", rf_write_reg, 4);

    // Reserve x7, then load/store writes it back
    step;
    rsv_valid = 1'b1; rsv_reg = 5'd7; chk_reg1 = 5'd7;
    smp;
    check("rsv7_same_cycle", hazard1, 0);
    step;
    rsv_valid = 1'b0;
    smp;
    check("rsv7_pending", hazard1, 1);
    step;
    wb.req1_valid = 1'b1; wb.req1 = '{dst: 5'd7, data: 32'h77};
    smp;
    check("wb7_rdy1", wb.req1_ready, 1);
    check("wb7_hz_xfer", hazard1, 1);
    step;
    wb.req1_valid = 1'b0;
    smp;
    check("wb7_we",  rf_write_enable, 1);
    check("wb7_reg", rf_write_reg, 7);
    check("wb7_hz_write", hazard1, 1);
    step;
    smp;
    check("wb7_hz_clear", hazard1, 0);

    // Set and clear of x9 in the same cycle: set wins
    step;
    wb.req0_valid = 1'b1; wb.req0 = '{dst: 5'd9, data: 32'h99};
    chk_reg2 = 5'd9;
    smp;
    check("x9_rdy0", wb.req0_ready, 1);
    step;
    wb.req0_valid = 1'b0;
    rsv_valid = 1'b1; rsv_reg = 5'd9;
    smp;
    check("x9_we",  rf_write_enable, 1);
    check("x9_reg", rf_write_reg, 9);
    step;
    rsv_valid = 1'b0;
    smp;
    check("x9_set_wins", hazard2, 1);

    // Request to x0 is swallowed; x0 never hazards
    step;
    wb.req0_valid = 1'b1; wb.req0 = '{dst: 5'd0, data: 32'h1234};
    rsv_valid = 1'b1; rsv_reg = 5'd0; chk_reg1 = 5'd0;
    smp;
    check("x0_rdy0", wb.req0_ready, 1);
    check("x0_hz1",  hazard1, 0);
    step;
    wb.req0_valid = 1'b0; rsv_valid = 1'b0;
    smp;
    check("x0_we",      rf_write_enable, 0);
    check("x0_hz1_nxt", hazard1, 0);
    check("x9_still",   hazard2, 1);

    // Flush with pending {2,6} and a live request
    step;
    rsv_valid = 1'b1; rsv_reg = 5'd2;
    step;
    rsv_reg = 5'd6;
    step;
    rsv_valid = 1'b0; chk_reg1 = 5'd2; chk_reg2 = 5'd6;
    smp;
    check("pre_flush_hz1", hazard1, 1);
    check("pre_flush_hz2", hazard2, 1);
    step;
    flush = 1'b1;
    wb.req0_valid = 1'b1; wb.req0 = '{dst: 5'd2, data: 32'h22};
    rsv_valid = 1'b1; rsv_reg = 5'd3;
    smp;
    check("flush_rdy0", wb.req0_ready, 0);
    check("flush_rdy1", wb.req1_ready, 0);
    step;
    flush = 1'b0; wb.req0_valid = 1'b0; rsv_valid = 1'b0;
    smp;
    check("flush_hz1", hazard1, 0);
    check("flush_hz2", hazard2, 0);
    check("flush_we",  rf_write_enable, 0);
    chk_reg1 = 5'd3; chk_reg2 = 5'd9;
    #1;
    check("flush_rsv_ignored", hazard1, 0);
    check("flush_x9_clear",    hazard2, 0);

    // Reset right after a transfer drops the write
    step;
    wb.req0_valid = 1'b1; wb.req0 = '{dst: 5'd8, data: 32'h88};
    smp;
    check("rst_xfer_rdy0", wb.req0_ready, 1);
    step;
    wb.req0_valid = 1'b0; reset = 1'b1;
    smp;
    check("rst_drop_we", rf_write_enable, 0);
    step;
    reset = 1'b0;
    smp;
    check("rst_after_we",   rf_write_enable, 0);
    check("rst_after_reg",  rf_write_reg, 0);
    check("rst_after_data", rf_write_data, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
